// File: rtl/scope_pkg.sv
// scope_pkg: shared state encoding, state width and default buffer address width
package scope_pkg;
  localparam int STATE_W    = 3;
  localparam int DEF_ADDR_W = 10;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;
endpackage

// File: rtl/scope_trig_det.sv
// scope_trig_det: previous-sample tracker and edge/level trigger comparator
module scope_trig_det (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       upd_i,
  input  logic       en_i,
  input  logic [7:0] smp_i,
  input  logic [7:0] level_i,
  input  logic       fall_i,
  output logic       hit_o
);
  logic [7:0] prev_q;
  logic       pv_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      pv_q   <= 1'b0;
    end else if (clr_i) begin
      pv_q   <= 1'b0;
    end else if (upd_i) begin
      prev_q <= smp_i;
      pv_q   <= 1'b1;
    end
  end
  // Equal-to-level on both sides is not a crossing
  assign hit_o = en_i & pv_q & (fall_i ? (prev_q >= level_i && smp_i < level_i)
                                       : (prev_q < level_i && smp_i >= level_i));
endmodule

// File: rtl/scope_acq_ctrl.sv
// scope_acq_ctrl: oscilloscope acquisition controller with pre/post-trigger ring buffer
// Build option SCOPE_AUTO_TRIG_EN adds an ARMED-sample timeout that forces a trigger.
module scope_acq_ctrl
  import scope_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int PRETRIG      = 512,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic               CLK_50M,
  input  logic               RST,
  input  logic               SMP_VALID,
  input  logic [7:0]         SMP_DATA,
  input  logic [7:0]         TRIG_LEVEL,
  input  logic               TRIG_FALL,
  input  logic               SINGLE,
  input  logic               ARM,
  input  logic               STOP,
  input  logic               FRAME_ACK,
  output logic               WR_EN,
  output logic [ADDR_W-1:0]  WR_ADDR,
  output logic [7:0]         WR_DATA,
  output logic               FRAME_READY,
  output logic [ADDR_W-1:0]  START_ADDR,
  output logic               AUTO_FLAG,
  output logic [STATE_W-1:0] STATE
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int POST  = DEPTH - PRETRIG;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, pcnt_q, post_q, trig_addr_q, wr_addr_q, start_q;
  logic [7:0] wr_data_q;
  logic wr_en_q, ready_q, auto_q;
  logic act, hit, force_trig, fire, pre_done, post_done, ack, enter_pre, enter_hold;
  scope_trig_det u_det (
    .clk     (CLK_50M),
    .rst     (RST),
    .clr_i   (enter_pre),
    .upd_i   (act),
    .en_i    (SMP_VALID && state_q == S_ARMED),
    .smp_i   (SMP_DATA),
    .level_i (TRIG_LEVEL),
    .fall_i  (TRIG_FALL),
    .hit_o   (hit)
  );
`ifdef SCOPE_AUTO_TRIG_EN
  logic [31:0] acnt_q;
  logic enter_armed;
  assign enter_armed = state_d == S_ARMED && state_q != S_ARMED;
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) acnt_q <= '0;
    else if (enter_armed) acnt_q <= '0;
    else if (SMP_VALID && state_q == S_ARMED) acnt_q <= acnt_q + 32'd1;
  end
  assign force_trig = acnt_q == 32'(AUTO_TIMEOUT - 1);
`else
  assign force_trig = 1'b0;
`endif
  always_comb begin
    act        = SMP_VALID & ~STOP & (state_q == S_PRE || state_q == S_ARMED || state_q == S_POST);
    fire       = act & (state_q == S_ARMED) & (hit | force_trig);
    pre_done   = act & (state_q == S_PRE) & (pcnt_q == ADDR_W'(PRETRIG - 1));
    post_done  = act & (state_q == S_POST) & (post_q == ADDR_W'(POST - 1));
    ack        = (state_q == S_HOLD) & FRAME_ACK & ready_q;
    enter_pre  = state_d == S_PRE && state_q != S_PRE;
    enter_hold = state_d == S_HOLD && state_q != S_HOLD;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = ARM ? S_PRE : S_IDLE;
      S_PRE:   state_d = pre_done ? S_ARMED : S_PRE;
      S_ARMED: state_d = fire ? ((POST == 1) ? S_HOLD : S_POST) : S_ARMED;
      S_POST:  state_d = post_done ? S_HOLD : S_POST;
      S_HOLD:  state_d = ack ? (SINGLE ? S_IDLE : S_PRE) : S_HOLD;
      default: state_d = S_IDLE;
    endcase
    if (STOP) state_d = S_IDLE;
  end
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      pcnt_q      <= '0;
      post_q      <= '0;
      trig_addr_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ready_q     <= 1'b0;
      start_q     <= '0;
      auto_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= act;
      ready_q <= state_d == S_HOLD;
      if (act) begin
        wr_addr_q <= wptr_q;
        wr_data_q <= SMP_DATA;
        wptr_q    <= wptr_q + 1'b1;
      end
      if (enter_pre) pcnt_q <= '0;
      else if (act && state_q == S_PRE) pcnt_q <= pcnt_q + 1'b1;
      if (fire) begin
        post_q      <= ADDR_W'(1);
        trig_addr_q <= wptr_q;
        auto_q      <= force_trig & ~hit;
      end else if (act && state_q == S_POST) begin
        post_q <= post_q + 1'b1;
      end
      // Trigger address may be captured in this very cycle when the frame has one post sample
      if (enter_hold) start_q <= (fire ? wptr_q : trig_addr_q) - ADDR_W'(PRETRIG);
    end
  end
  assign WR_EN       = wr_en_q;
  assign WR_ADDR     = wr_addr_q;
  assign WR_DATA     = wr_data_q;
  assign FRAME_READY = ready_q;
  assign START_ADDR  = start_q;
  assign AUTO_FLAG   = auto_q;
  assign STATE       = state_q;
endmodule

// File: tb/tb_scope_acq_ctrl.sv
// tb_scope_acq_ctrl: directed bench for scope_acq_ctrl with ADDR_W=4, PRETRIG=4, AUTO_TIMEOUT=8
module tb_scope_acq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic smp_valid = 1'b0, trig_fall = 1'b0, single = 1'b1, arm = 1'b0, stop = 1'b0, frame_ack = 1'b0;
  logic [7:0] smp_data = '0, trig_level = '0;
  logic wr_en, frame_ready, auto_flag;
  logic [3:0] wr_addr, start_addr;
  logic [7:0] wr_data;
  logic [2:0] state;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  scope_acq_ctrl #(.ADDR_W(4), .PRETRIG(4), .AUTO_TIMEOUT(8)) dut (
    .CLK_50M     (clk),
    .RST         (rst),
    .SMP_VALID   (smp_valid),
    .SMP_DATA    (smp_data),
    .TRIG_LEVEL  (trig_level),
    .TRIG_FALL   (trig_fall),
    .SINGLE      (single),
    .ARM         (arm),
    .STOP        (stop),
    .FRAME_ACK   (frame_ack),
    .WR_EN       (wr_en),
    .WR_ADDR     (wr_addr),
    .WR_DATA     (wr_data),
    .FRAME_READY (frame_ready),
    .START_ADDR  (start_addr),
    .AUTO_FLAG   (auto_flag),
    .STATE       (state)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d);
    smp_data = d;
    smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
  endtask
  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_state", state, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ready", frame_ready, 0);
    chk("rst_start", start_addr, 0);
    chk("rst_auto", auto_flag, 0);
    rst = 1'b0;
    tick();
    send(8'h33);
    chk("idle_no_write", wr_en, 0);
    // Ramp frame: rising trigger at level 10
    trig_level = 8'd10;
    single = 1'b1;
    do_arm();
    chk("arm_pre", state, 1);
    for (int i = 0; i < 4; i++) send(8'(i));
    chk("pre_done_armed", state, 2);
    chk("pre_wr_addr", wr_addr, 3);
    chk("pre_wr_data", wr_data, 3);
    for (int i = 4; i < 10; i++) send(8'(i));
    chk("ramp_still_armed", state, 2);
    send(8'd10);
    chk("ramp_trig_state", state, 3);
    chk("ramp_trig_addr", wr_addr, 10);
    chk("ramp_trig_wr_en", wr_en, 1);
    for (int i = 11; i < 21; i++) send(8'(i));
    chk("ramp_post_state", state, 3);
    chk("ramp_post_ready", frame_ready, 0);
    send(8'd21);
    chk("ramp_hold_state", state, 4);
    chk("ramp_ready", frame_ready, 1);
    chk("ramp_start", start_addr, 6);
    chk("ramp_auto", auto_flag, 0);
    chk("ramp_last_addr", wr_addr, 5);
    send(8'h55);
    chk("hold_no_write", wr_en, 0);
    chk("hold_stays", state, 4);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("single_ack_idle", state, 0);
    chk("single_ack_ready", frame_ready, 0);
    // Continuous mode with pointer wrap; FRAME_ACK outside HOLD ignored
    single = 1'b0;
    do_arm();
    for (int i = 0; i < 4; i++) send(8'd5);
    chk("cont_pre_addr", wr_addr, 9);
    frame_ack = 1'b1;
    send(8'd5);
    frame_ack = 1'b0;
    chk("ack_ignored", state, 2);
    for (int i = 0; i < 5; i++) send(8'd5);
    chk("cont_addr_15", wr_addr, 15);
    send(8'd20);
    chk("cont_trig_state", state, 3);
    chk("cont_wrap_addr", wr_addr, 0);
    for (int i = 0; i < 11; i++) send(8'd20);
    chk("cont_hold", state, 4);
    chk("cont_start", start_addr, 12);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("cont_ack_ready", frame_ready, 0);
    chk("cont_ack_pre", state, 1);
    send(8'd1);
    chk("cont_ptr_continues", wr_addr, 12);
    do_stop();
    chk("stop_from_pre", state, 0);
    // Falling edge trigger and level-equal non-crossing
    single = 1'b1;
    trig_fall = 1'b1;
    trig_level = 8'h80;
    do_arm();
    for (int i = 0; i < 4; i++) send(8'h80);
    send(8'h80);
    send(8'h80);
    chk("fall_equal_no_trig", state, 2);
    send(8'h90);
    chk("fall_above_armed", state, 2);
    send(8'h70);
    chk("fall_trig", state, 3);
    chk("fall_trig_data", wr_data, 8'h70);
    do_stop();
    chk("fall_stop", state, 0);
    chk("fall_stop_wr_en", wr_en, 0);
    // Constant signal below level: auto trigger only with the timeout build
    trig_fall = 1'b0;
    do_arm();
    for (int i = 0; i < 4; i++) send(8'h20);
    for (int i = 0; i < 7; i++) send(8'h20);
    chk("auto_7_armed", state, 2);
    send(8'h20);
`ifdef SCOPE_AUTO_TRIG_EN
    chk("auto_fire_state", state, 3);
    for (int i = 0; i < 11; i++) send(8'h20);
    chk("auto_hold", state, 4);
    chk("auto_flag", auto_flag, 1);
`else
    chk("noauto_armed", state, 2);
    for (int i = 0; i < 20; i++) send(8'h20);
    chk("noauto_still_armed", state, 2);
    chk("noauto_flag", auto_flag, 0);
`endif
    do_stop();
    chk("auto_stop", state, 0);
    chk("auto_stop_ready", frame_ready, 0);
    // STOP wins over a crossing sample in ARMED
    do_arm();
    for (int i = 0; i < 4; i++) send(8'h10);
    stop = 1'b1;
    send(8'h90);
    stop = 1'b0;
    chk("stop_vs_trig_state", state, 0);
    chk("stop_vs_trig_wr_en", wr_en, 0);
    tick();
    chk("stop_no_post", state, 0);
    // Asynchronous reset during POSTTRIG
    do_arm();
    for (int i = 0; i < 4; i++) send(8'h10);
    send(8'h90);
    chk("rst_mid_post", state, 3);
    chk("rst_mid_data", wr_data, 8'h90);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_ready", frame_ready, 0);
    chk("arst_start", start_addr, 0);
    chk("arst_auto", auto_flag, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
